// File: rtl/store_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_pkg: funct3 codes, FSM states and access-size helper            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package store_pkg;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Access size in bytes; reserved encodings return 0.
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    case (funct3)
      SB:      size_of = 4'd1;
      SH:      size_of = 4'd2;
      SW:      size_of = 4'd4;
      SD:      size_of = 4'd8;
      default: size_of = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_lane_align: big-endian lane placement of a store over two beats |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module store_lane_align #(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OW     = $clog2(DATA_W / 8)
) (
  input  logic [OW-1:0]     offset,
  input  logic [3:0]        size,
  input  logic [DATA_W-1:0] data,
  output logic [NB-1:0]     ena0,
  output logic [NB-1:0]     ena1,
  output logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] wdata1,
  output logic              split
);

  localparam int SHW = $clog2(DATA_W) + 1;

  logic [SHW-1:0]        w_lsh;
  logic [SHW-1:0]        w_osh;
  logic [DATA_W-1:0]     w_lj;
  logic [2*DATA_W-1:0]   w_dbl;
  logic [NB-1:0]         w_mask;
  logic [2*NB-1:0]       w_mdbl;

  // Left-justify the stored bytes, then slide them right by the offset
  // across a two-word window; the upper word is beat 0, the lower beat 1.
  assign w_lsh  = SHW'(8 * (NB - int'(size)));
  assign w_osh  = SHW'(8 * int'(offset));
  assign w_lj   = data << w_lsh;
  assign w_dbl  = {w_lj, {DATA_W{1'b0}}} >> w_osh;
  assign w_mask = ~({NB{1'b1}} >> size);
  assign w_mdbl = {w_mask, {NB{1'b0}}} >> offset;

  assign wdata0 = w_dbl[2*DATA_W-1:DATA_W];
  assign wdata1 = w_dbl[DATA_W-1:0];
  assign ena0   = w_mdbl[2*NB-1:NB];
  assign ena1   = w_mdbl[NB-1:0];
  assign split  = |w_mdbl[NB-1:0];

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_unit: store path from execute to a valid/ready memory write port|
// | Option macro: STORE_UNIT_MISALIGN_SPLIT_EN (split word-crossing store)|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byte_ena,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                done,
  output logic                err
);

  import store_pkg::*;

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  state_t              r_state;
  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [NB-1:0]       r_mem_ena;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_done;
  logic                r_err;

  logic [3:0]          w_size;
  logic [NB-1:0]       w_ena0;
  logic [NB-1:0]       w_ena1;
  logic [DATA_W-1:0]   w_wdata0;
  logic [DATA_W-1:0]   w_wdata1;
  logic                w_split;
  logic                w_bad_f3;
  logic                w_illegal;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_word0;

  assign w_size   = size_of(req_funct3);
  assign w_bad_f3 = req_funct3[2] || ((req_funct3 == SD) && (DATA_W == 32));
  assign w_word0  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};

  store_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .offset (req_addr[OW-1:0]),
    .size   (w_size),
    .data   (req_data),
    .ena0   (w_ena0),
    .ena1   (w_ena1),
    .wdata0 (w_wdata0),
    .wdata1 (w_wdata1),
    .split  (w_split)
  );

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
  logic                r_split;
  logic [NB-1:0]       r_b1_ena;
  logic [DATA_W-1:0]   r_b1_wdata;

  assign w_illegal = w_bad_f3;
`else
  logic w_unused_b1;

  assign w_unused_b1 = ^{w_ena1, w_wdata1};
  assign w_illegal   = w_bad_f3 || w_split;
`endif

  // Ready is gated by rst so it reads low throughout the reset cycle.
  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_ena   <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
      r_split     <= 1'b0;
      r_b1_ena    <= '0;
      r_b1_wdata  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_state     <= BEAT0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_word0;
              r_mem_ena   <= w_ena0;
              r_mem_wdata <= w_wdata0;
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
              r_split     <= w_split;
              r_b1_ena    <= w_ena1;
              r_b1_wdata  <= w_wdata1;
`endif
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
            if (r_split) begin
              r_state     <= BEAT1;
              r_mem_addr  <= r_mem_addr + ADDR_W'(NB);
              r_mem_ena   <= r_b1_ena;
              r_mem_wdata <= r_b1_wdata;
            end else begin
              r_state     <= IDLE;
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
            end
`else
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
`endif
          end
        end
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
        BEAT1: begin
          if (mem_ready) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_valid    = r_mem_valid;
  assign mem_addr     = r_mem_addr;
  assign mem_byte_ena = r_mem_ena;
  assign mem_wdata    = r_mem_wdata;
  assign done         = r_done;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_store_unit: directed self-checking bench, 32- and 64-bit instances |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        x32_req_valid, x32_req_ready;
  logic [2:0]  x32_req_funct3;
  logic [31:0] x32_req_addr, x32_req_data;
  logic        x32_mem_valid, x32_mem_ready;
  logic [31:0] x32_mem_addr;
  logic [3:0]  x32_mem_byte_ena;
  logic [31:0] x32_mem_wdata;
  logic        x32_done, x32_err;

  logic        x64_req_valid, x64_req_ready;
  logic [2:0]  x64_req_funct3;
  logic [31:0] x64_req_addr;
  logic [63:0] x64_req_data;
  logic        x64_mem_valid, x64_mem_ready;
  logic [31:0] x64_mem_addr;
  logic [7:0]  x64_mem_byte_ena;
  logic [63:0] x64_mem_wdata;
  logic        x64_done, x64_err;

  store_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(x32_req_valid), .req_ready(x32_req_ready),
    .req_funct3(x32_req_funct3), .req_addr(x32_req_addr), .req_data(x32_req_data),
    .mem_valid(x32_mem_valid), .mem_ready(x32_mem_ready), .mem_addr(x32_mem_addr),
    .mem_byte_ena(x32_mem_byte_ena), .mem_wdata(x32_mem_wdata),
    .done(x32_done), .err(x32_err)
  );

  store_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(x64_req_valid), .req_ready(x64_req_ready),
    .req_funct3(x64_req_funct3), .req_addr(x64_req_addr), .req_data(x64_req_data),
    .mem_valid(x64_mem_valid), .mem_ready(x64_mem_ready), .mem_addr(x64_mem_addr),
    .mem_byte_ena(x64_mem_byte_ena), .mem_wdata(x64_mem_wdata),
    .done(x64_done), .err(x64_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    x32_req_valid  = 1'b1;
    x32_req_funct3 = f;
    x32_req_addr   = a;
    x32_req_data   = d;
    step();
    x32_req_valid  = 1'b0;
  endtask

  task automatic issue64(input logic [2:0] f, input logic [31:0] a, input logic [63:0] d);
    x64_req_valid  = 1'b1;
    x64_req_funct3 = f;
    x64_req_addr   = a;
    x64_req_data   = d;
    step();
    x64_req_valid  = 1'b0;
  endtask

  task automatic beat32(input string tag, input logic [31:0] a, input logic [3:0] e,
                        input logic [31:0] d);
    chk({tag, "_valid"}, 64'(x32_mem_valid), 64'(1'b1));
    chk({tag, "_addr"},  64'(x32_mem_addr), 64'(a));
    chk({tag, "_ena"},   64'(x32_mem_byte_ena), 64'(e));
    chk({tag, "_wdata"}, 64'(x32_mem_wdata), 64'(d));
    chk({tag, "_nodone"}, 64'(x32_done), 64'(1'b0));
  endtask

  task automatic beat64(input string tag, input logic [31:0] a, input logic [7:0] e,
                        input logic [63:0] d);
    chk({tag, "_valid"}, 64'(x64_mem_valid), 64'(1'b1));
    chk({tag, "_addr"},  64'(x64_mem_addr), 64'(a));
    chk({tag, "_ena"},   64'(x64_mem_byte_ena), 64'(e));
    chk({tag, "_wdata"}, x64_mem_wdata, d);
    chk({tag, "_nodone"}, 64'(x64_done), 64'(1'b0));
  endtask

  task automatic fin32(input string tag);
    chk({tag, "_done"},  64'(x32_done), 64'(1'b1));
    chk({tag, "_vlow"},  64'(x32_mem_valid), 64'(1'b0));
    chk({tag, "_ready"}, 64'(x32_req_ready), 64'(1'b1));
  endtask

  task automatic err32(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    issue32(f, a, d);
    chk({tag, "_err"},    64'(x32_err), 64'(1'b1));
    chk({tag, "_novld"},  64'(x32_mem_valid), 64'(1'b0));
    chk({tag, "_nodone"}, 64'(x32_done), 64'(1'b0));
    step();
    chk({tag, "_errlow"}, 64'(x32_err), 64'(1'b0));
    chk({tag, "_novld2"}, 64'(x32_mem_valid), 64'(1'b0));
    chk({tag, "_ready"},  64'(x32_req_ready), 64'(1'b1));
  endtask

  initial begin
    rst = 1'b1;
    x32_req_valid = 1'b0; x32_req_funct3 = '0; x32_req_addr = '0; x32_req_data = '0;
    x64_req_valid = 1'b0; x64_req_funct3 = '0; x64_req_addr = '0; x64_req_data = '0;
    x32_mem_ready = 1'b0; x64_mem_ready = 1'b0;
    step();
    step();
    chk("rst_ready32", 64'(x32_req_ready), 64'(1'b0));
    chk("rst_ready64", 64'(x64_req_ready), 64'(1'b0));
    rst = 1'b0;
    #1;
    chk("post_ready32", 64'(x32_req_ready), 64'(1'b1));
    chk("post_valid32", 64'(x32_mem_valid), 64'(1'b0));
    chk("post_addr32",  64'(x32_mem_addr), 64'(0));
    chk("post_ena32",   64'(x32_mem_byte_ena), 64'(0));
    chk("post_wdata32", 64'(x32_mem_wdata), 64'(0));
    chk("post_done32",  64'(x32_done), 64'(1'b0));
    chk("post_err32",   64'(x32_err), 64'(1'b0));
    chk("post_valid64", 64'(x64_mem_valid), 64'(1'b0));
    chk("post_ready64", 64'(x64_req_ready), 64'(1'b1));

    x32_mem_ready = 1'b1;
    x64_mem_ready = 1'b1;

    issue32(3'b000, 32'h0000_0103, 32'hAABB_CCDD);
    beat32("sb103", 32'h100, 4'b0001, 32'h0000_00DD);
    chk("sb103_busy", 64'(x32_req_ready), 64'(1'b0));
    step();
    fin32("sb103");

    issue32(3'b001, 32'h0000_0200, 32'h0000_1234);
    beat32("sh200", 32'h200, 4'b1100, 32'h1234_0000);
    step();
    fin32("sh200");

    issue32(3'b010, 32'h0000_0204, 32'hCAFE_F00D);
    beat32("sw204", 32'h204, 4'b1111, 32'hCAFE_F00D);
    step();
    fin32("sw204");

    issue32(3'b001, 32'h0000_0401, 32'h0000_BEEF);
    beat32("sh401", 32'h400, 4'b0110, 32'h00BE_EF00);
    step();
    fin32("sh401");

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
    issue32(3'b010, 32'h0000_0302, 32'h1122_3344);
    beat32("sw302_b0", 32'h300, 4'b0011, 32'h0000_1122);
    step();
    beat32("sw302_b1", 32'h304, 4'b1100, 32'h3344_0000);
    step();
    fin32("sw302");
    step();
    chk("sw302_donelow", 64'(x32_done), 64'(1'b0));
`else
    err32("sw302_cross", 3'b010, 32'h0000_0302, 32'h1122_3344);
`endif

    err32("f3_111", 3'b111, 32'h0000_0500, 32'h5555_5555);
    err32("sd_on32", 3'b011, 32'h0000_0508, 32'h7777_7777);

    // Wide instance: SD held off by mem_ready for three cycles.
    x64_mem_ready = 1'b0;
    issue64(3'b011, 32'h0000_0008, 64'h0102_0304_0506_0708);
    for (int i = 0; i < 3; i++) begin
      beat64($sformatf("sd8_stall%0d", i), 32'h8, 8'hFF, 64'h0102_0304_0506_0708);
      step();
    end
    x64_mem_ready = 1'b1;
    beat64("sd8_go", 32'h8, 8'hFF, 64'h0102_0304_0506_0708);
    step();
    chk("sd8_done",  64'(x64_done), 64'(1'b1));
    chk("sd8_vlow",  64'(x64_mem_valid), 64'(1'b0));
    step();
    chk("sd8_donelow", 64'(x64_done), 64'(1'b0));

    issue64(3'b000, 32'h0000_000F, 64'h0000_0000_0000_00EE);
    beat64("sb0f", 32'h8, 8'h01, 64'h0000_0000_0000_00EE);
    step();
    chk("sb0f_done", 64'(x64_done), 64'(1'b1));

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
    issue64(3'b010, 32'h0000_000E, 64'h0000_0000_A1B2_C3D4);
    beat64("sw0e_b0", 32'h8, 8'h03, 64'h0000_0000_0000_A1B2);
    step();
    beat64("sw0e_b1", 32'h10, 8'hC0, 64'hC3D4_0000_0000_0000);
    step();
    chk("sw0e_done", 64'(x64_done), 64'(1'b1));
`else
    issue64(3'b010, 32'h0000_000E, 64'h0000_0000_A1B2_C3D4);
    chk("sw0e_err",   64'(x64_err), 64'(1'b1));
    chk("sw0e_novld", 64'(x64_mem_valid), 64'(1'b0));
    step();
    chk("sw0e_errlow", 64'(x64_err), 64'(1'b0));
`endif

    // Reset while a beat is outstanding.
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
    issue32(3'b010, 32'h0000_0302, 32'h1122_3344);
    step();
    beat32("rstb1", 32'h304, 4'b1100, 32'h3344_0000);
`else
    x32_mem_ready = 1'b0;
    issue32(3'b010, 32'h0000_0600, 32'hDEAD_BEEF);
    beat32("rstb0", 32'h600, 4'b1111, 32'hDEAD_BEEF);
`endif
    rst = 1'b1;
    x32_mem_ready = 1'b0;
    step();
    chk("mid_rst_valid", 64'(x32_mem_valid), 64'(1'b0));
    chk("mid_rst_addr",  64'(x32_mem_addr), 64'(0));
    chk("mid_rst_ena",   64'(x32_mem_byte_ena), 64'(0));
    chk("mid_rst_wdata", 64'(x32_mem_wdata), 64'(0));
    chk("mid_rst_done",  64'(x32_done), 64'(1'b0));
    chk("mid_rst_err",   64'(x32_err), 64'(1'b0));
    chk("mid_rst_ready", 64'(x32_req_ready), 64'(1'b0));
    rst = 1'b0;
    #1;
    chk("after_rst_ready", 64'(x32_req_ready), 64'(1'b1));
    step();
    chk("after_rst_done",  64'(x32_done), 64'(1'b0));
    chk("after_rst_valid", 64'(x32_mem_valid), 64'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
